cmac_test_ctrl: RTL and testbench

- Per-port sequencer for one CMAC loopback/traffic test instance. Sits between the XDMA AXI GPIO word and a cmac0/cmac1 instance, replacing direct GPIO wiring of sys_reset/lbus_tx_rx_restart_in/send_continuous_pkts.
- Software issues start/abort commands. The block runs the reset → GT lock → alignment → LBUS restart → traffic sequence with timeouts, then reports a 16-bit status word back on the GPIO input half.

---
 rtl/cmac_test_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_cmac_test_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_test_ctrl.sv
// Per-port CMAC test sequencer: reset -> GT lock -> alignment -> LBUS restart
// -> traffic, with timeouts, driven by GPIO start/abort levels and reporting a
// 16-bit status word back to software.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | parked, CMAC held in reset, waiting for a start edge
// RESET       | sys_reset held for RESET_CYCLES
// WAIT_LOCK   | waiting for rx_gt_locked, LOCK_TIMEOUT guard
// WAIT_ALIGN  | waiting for rx_aligned, ALIGN_TIMEOUT guard
// RESTART     | lbus_tx_rx_restart pulsed for RESTART_CYCLES
// RUN         | traffic running, monitoring alignment and data errors
// DONE        | single-shot run passed, waiting for start or abort
// FAIL        | run failed (err holds cause), waiting for start or abort
module cmac_test_ctrl #(
  parameter int unsigned RESET_CYCLES   = 64,
  parameter int unsigned RESTART_CYCLES = 8,
  parameter logic [31:0] LOCK_TIMEOUT   = 32'd10000000,
  parameter logic [31:0] ALIGN_TIMEOUT  = 32'd10000000,
  parameter logic [31:0] RUN_TIMEOUT    = 32'd100000000
) (
  input  logic        init_clk,
  input  logic        sys_rstn,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        cmd_loopback,
  input  logic        cmd_continuous,
  input  logic        rx_gt_locked,
  input  logic        rx_aligned,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic        rx_data_fail,
  output logic        sys_reset,
  output logic        loopback_en,
  output logic        lbus_tx_rx_restart,
  output logic        send_continuous_pkts,
  output logic [15:0] status
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_RESTART    = 3'd4,
    ST_RUN        = 3'd5,
    ST_DONE       = 3'd6,
    ST_FAIL       = 3'd7
  } state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_LOCK      = 3'd1;
  localparam logic [2:0] ERR_ALIGN     = 3'd2;
  localparam logic [2:0] ERR_ALIGN_RUN = 3'd3;
  localparam logic [2:0] ERR_DATA      = 3'd4;
  localparam logic [2:0] ERR_RUN       = 3'd5;

  // Timer terminal counts: a state lasts exactly N cycles when it exits at N-1.
  localparam logic [31:0] RESET_LAST   = 32'(RESET_CYCLES) - 32'd1;
  localparam logic [31:0] RESTART_LAST = 32'(RESTART_CYCLES) - 32'd1;
  localparam logic [31:0] LOCK_LAST    = LOCK_TIMEOUT - 32'd1;
  localparam logic [31:0] ALIGN_LAST   = ALIGN_TIMEOUT - 32'd1;
  localparam logic [31:0] RUN_LAST     = RUN_TIMEOUT - 32'd1;

  logic [8:0] async_in;
  logic [8:0] sync_meta;
  logic [8:0] sync_q;
  logic       s_start, s_abort, s_loopback, s_continuous;
  logic       s_locked, s_aligned, s_tx_done, s_rx_done, s_data_fail;
  logic       s_start_d;
  logic       start_edge;

  state_t      state, state_next;
  logic [31:0] timer;
  logic        lb_q, lb_next;
  logic        cont_q, cont_next;
  logic        pass_q, pass_next;
  logic        fail_q, fail_next;
  logic [2:0]  err_q, err_next;
  logic [6:0]  pass_count, pc_next;
  logic        tx_seen, rx_seen;
  logic        busy;

  assign async_in = {cmd_start, cmd_abort, cmd_loopback, cmd_continuous,
                     rx_gt_locked, rx_aligned, tx_done, rx_done, rx_data_fail};
  assign {s_start, s_abort, s_loopback, s_continuous,
          s_locked, s_aligned, s_tx_done, s_rx_done, s_data_fail} = sync_q;
  assign start_edge = s_start & ~s_start_d;

  // Two-flop synchronisers for GPIO levels and CMAC status LEDs, plus start edge delay.
  always_ff @(posedge init_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_meta <= '0;
      sync_q    <= '0;
      s_start_d <= 1'b0;
    end else begin
      sync_meta <= async_in;
      sync_q    <= sync_meta;
      s_start_d <= s_start;
    end
  end

  // State, flags, per-run latches and the state timer.
  always_ff @(posedge init_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state      <= ST_IDLE;
      timer      <= '0;
      lb_q       <= 1'b0;
      cont_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= ERR_NONE;
      pass_count <= '0;
      tx_seen    <= 1'b0;
      rx_seen    <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= (state_next != state) ? 32'd0 : timer + 32'd1;
      lb_q       <= lb_next;
      cont_q     <= cont_next;
      pass_q     <= pass_next;
      fail_q     <= fail_next;
      err_q      <= err_next;
      pass_count <= pc_next;
      if (state_next == ST_RUN && state != ST_RUN) begin
        tx_seen <= 1'b0;
        rx_seen <= 1'b0;
      end else if (state == ST_RUN) begin
        tx_seen <= tx_seen | s_tx_done;
        rx_seen <= rx_seen | s_rx_done;
      end
    end
  end

  // Next-state and flag updates; abort overrides everything and keeps the flags.
  always_comb begin
    state_next = state;
    lb_next    = lb_q;
    cont_next  = cont_q;
    pass_next  = pass_q;
    fail_next  = fail_q;
    err_next   = err_q;
    pc_next    = pass_count;
    if (s_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_edge) begin
            state_next = ST_RESET;
            lb_next    = s_loopback;
            cont_next  = s_continuous;
            pass_next  = 1'b0;
            fail_next  = 1'b0;
            err_next   = ERR_NONE;
          end
        end
        ST_RESET: begin
          if (timer == RESET_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (s_locked) begin
            state_next = ST_WAIT_ALIGN;
          end else if (timer == LOCK_LAST) begin
            state_next = ST_FAIL;
            fail_next  = 1'b1;
            err_next   = ERR_LOCK;
          end
        end
        ST_WAIT_ALIGN: begin
          if (s_aligned) begin
            state_next = ST_RESTART;
          end else if (timer == ALIGN_LAST) begin
            state_next = ST_FAIL;
            fail_next  = 1'b1;
            err_next   = ERR_ALIGN;
          end
        end
        ST_RESTART: begin
          if (timer == RESTART_LAST) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (s_data_fail) begin
            state_next = ST_FAIL;
            fail_next  = 1'b1;
            err_next   = ERR_DATA;
          end else if (!s_aligned) begin
            state_next = ST_FAIL;
            fail_next  = 1'b1;
            err_next   = ERR_ALIGN_RUN;
          end else if (!cont_q) begin
            if ((tx_seen | s_tx_done) && (rx_seen | s_rx_done)) begin
              state_next = ST_DONE;
              pass_next  = 1'b1;
              pc_next    = (pass_count == 7'd127) ? pass_count : pass_count + 7'd1;
            end else if (timer == RUN_LAST) begin
              state_next = ST_FAIL;
              fail_next  = 1'b1;
              err_next   = ERR_RUN;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RESET) || (state == ST_WAIT_LOCK) || (state == ST_WAIT_ALIGN) ||
                (state == ST_RESTART) || (state == ST_RUN);

  // Registered CMAC controls decoded from the next state so they change with the state.
  always_ff @(posedge init_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sys_reset            <= 1'b1;
      loopback_en          <= 1'b0;
      lbus_tx_rx_restart   <= 1'b0;
      send_continuous_pkts <= 1'b0;
      status               <= '0;
    end else begin
      sys_reset            <= (state_next == ST_IDLE) || (state_next == ST_RESET);
      loopback_en          <= lb_next && (state_next != ST_IDLE) && (state_next != ST_RESET);
      lbus_tx_rx_restart   <= (state_next == ST_RESTART);
      send_continuous_pkts <= (state_next == ST_RUN) && cont_next;
      status               <= {pass_count, err_q, fail_q, pass_q, busy, state};
    end
  end

endmodule

// File: tb/tb_cmac_test_ctrl.sv
module tb_cmac_test_ctrl;

  logic        init_clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        cmd_start = 1'b0, cmd_abort = 1'b0, cmd_loopback = 1'b0, cmd_continuous = 1'b0;
  logic        rx_gt_locked = 1'b0, rx_aligned = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
  logic        rx_data_fail = 1'b0;
  logic        sys_reset, loopback_en, lbus_tx_rx_restart, send_continuous_pkts;
  logic [15:0] status;

  int checks = 0;
  int errors = 0;
  int m_pc = 0;  // model: completed passing runs, saturating at 127

  cmac_test_ctrl #(
    .RESET_CYCLES(64), .RESTART_CYCLES(8),
    .LOCK_TIMEOUT(32'd1000), .ALIGN_TIMEOUT(32'd1000), .RUN_TIMEOUT(32'd2000)
  ) dut (
    .init_clk(init_clk), .sys_rstn(sys_rstn),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_loopback(cmd_loopback),
    .cmd_continuous(cmd_continuous), .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned),
    .tx_done(tx_done), .rx_done(rx_done), .rx_data_fail(rx_data_fail),
    .sys_reset(sys_reset), .loopback_en(loopback_en), .lbus_tx_rx_restart(lbus_tx_rx_restart),
    .send_continuous_pkts(send_continuous_pkts), .status(status)
  );

  always #5 init_clk = ~init_clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge init_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [15:0] mk(input int pc, input int err, input bit f, input bit p,
                                     input bit busy, input int st);
    return {7'(pc), 3'(err), f, p, busy, 3'(st)};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 127) ? v + 1 : 127;
  endfunction

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (status[2:0] !== s && n < budget) begin
      step();
      n++;
    end
    check(tag, {29'd0, status[2:0]}, {29'd0, s});
  endtask

  // Single-shot run with lock/align already up. scen: 0 pass, 1 data fail,
  // 2 alignment lost, 3 run timeout, 4 data fail together with alignment loss.
  task automatic do_run(input bit lb, input int scen);
    int n, t_tx, t_rx, run_len;
    bit fin;
    logic [15:0] exp;
    cmd_start = 0; rx_gt_locked = 1; rx_aligned = 1;
    tx_done = 0; rx_done = 0; rx_data_fail = 0;
    step(4);
    cmd_loopback = lb; cmd_continuous = 0; cmd_start = 1;
    wait_state("reach_run", 3'd5, 300, n);
    t_tx = $urandom_range(1, 100);
    t_rx = $urandom_range(1, 100);
    fin = 0; run_len = 0;
    for (int j = 0; j < 2300 && !fin; j++) begin
      tx_done      = (scen == 0) && (j == t_tx);
      rx_done      = (scen == 0) && (j == t_rx);
      rx_data_fail = (scen == 1 || scen == 4) && (j == t_tx || j == t_tx + 1);
      rx_aligned   = !((scen == 2 || scen == 4) && j >= t_tx);
      step();
      if (status[2:0] == 3'd6 || status[2:0] == 3'd7) begin
        fin = 1;
        run_len = j + 1;
      end
    end
    tx_done = 0; rx_done = 0; rx_data_fail = 0; rx_aligned = 1;
    case (scen)
      0: begin m_pc = sat_inc(m_pc); exp = mk(m_pc, 0, 0, 1, 0, 6); end
      1, 4: exp = mk(m_pc, 4, 1, 0, 0, 7);
      2: exp = mk(m_pc, 3, 1, 0, 0, 7);
      default: exp = mk(m_pc, 5, 1, 0, 0, 7);
    endcase
    check($sformatf("run_status_s%0d", scen), {16'd0, status}, {16'd0, exp});
    check("run_loopback", {31'd0, loopback_en}, {31'd0, lb});
    check("run_scp_off", {31'd0, send_continuous_pkts}, 32'd0);
    check("run_sys_reset", {31'd0, sys_reset}, 32'd0);
    if (scen == 3) check("run_timeout_len", run_len, 32'd2000);
  endtask

  initial begin
    int n, c_reset, c_lbus, nst, nt;
    logic [2:0] walk [5];
    logic [2:0] last;
    logic p_prev, p_prev2;

    // Reset values
    step(3);
    check("rst_status", {16'd0, status}, 32'd0);
    check("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
    check("rst_ctrl", {29'd0, loopback_en, lbus_tx_rx_restart, send_continuous_pkts}, 32'd0);
    sys_rstn = 1;
    step(5);
    check("idle_status", {16'd0, status}, 32'd0);

    // First run: lock 100 and align 200 cycles after start; check state walk and pulse widths
    cmd_loopback = 1; cmd_continuous = 0; cmd_start = 1;
    c_reset = 0; c_lbus = 0; nst = 0; last = 3'd0;
    for (int i = 0; i < 400 && status[2:0] != 3'd5; i++) begin
      if (i == 100) rx_gt_locked = 1;
      if (i == 200) rx_aligned = 1;
      step();
      if (status[2:0] == 3'd1) c_reset++;
      if (lbus_tx_rx_restart) c_lbus++;
      if (status[2:0] != last && nst < 5) begin
        walk[nst] = status[2:0];
        nst++;
      end
      last = status[2:0];
    end
    check("walk_len", nst, 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("walk_%0d", k), {29'd0, walk[k]}, k + 1);
    check("reset_width", c_reset, 32'd64);
    check("restart_width", c_lbus, 32'd8);
    check("walk_loopback", {31'd0, loopback_en}, 32'd1);
    nt = 0;
    for (int j = 0; j < 300 && status[2:0] != 3'd6; j++) begin
      tx_done = (j == 50);
      rx_done = (j == 80);
      step();
    end
    tx_done = 0; rx_done = 0;
    m_pc = sat_inc(m_pc);
    check("first_done", {16'd0, status}, {16'd0, mk(m_pc, 0, 0, 1, 0, 6)});

    // Repeat passing runs until the pass counter saturates
    for (int r = 0; r < 129; r++) do_run(1'($urandom_range(0, 1)), 0);
    check("pc_saturated", {25'd0, status[15:9]}, 32'd127);

    // Randomised mix of outcomes, then a run timeout
    for (int r = 0; r < 12; r++) begin
      nt = $urandom_range(0, 3);
      do_run(1'($urandom_range(0, 1)), (nt == 3) ? 4 : nt);
    end
    do_run(1'b0, 3);

    // Lock never arrives: FAIL exactly LOCK_TIMEOUT cycles after entering WAIT_LOCK
    cmd_start = 0; rx_gt_locked = 0; rx_aligned = 0;
    step(4);
    cmd_start = 1;
    wait_state("lock_enter", 3'd2, 300, n);
    wait_state("lock_fail", 3'd7, 1200, n);
    check("lock_timeout_len", n, 32'd1000);
    check("lock_status", {16'd0, status}, {16'd0, mk(m_pc, 1, 1, 0, 0, 7)});

    // Continuous mode; cmd_* changes after start have no effect; data fail ends it
    cmd_start = 0; rx_gt_locked = 1; rx_aligned = 1;
    step(4);
    cmd_loopback = 1; cmd_continuous = 1; cmd_start = 1;
    wait_state("cont_run", 3'd5, 300, n);
    check("cont_scp_on", {31'd0, send_continuous_pkts}, 32'd1);
    cmd_continuous = 0; cmd_loopback = 0;
    step(500);
    check("cont_still_run", {29'd0, status[2:0]}, 32'd5);
    check("cont_scp_held", {31'd0, send_continuous_pkts}, 32'd1);
    check("cont_lb_held", {31'd0, loopback_en}, 32'd1);
    p_prev = send_continuous_pkts; p_prev2 = p_prev;
    rx_data_fail = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) rx_data_fail = 0;
      p_prev2 = p_prev;
      p_prev = send_continuous_pkts;
      step();
      if (status[2:0] == 3'd7) break;
    end
    rx_data_fail = 0;
    check("cont_fail_status", {16'd0, status}, {16'd0, mk(m_pc, 4, 1, 0, 0, 7)});
    check("scp_drop_edge", {30'd0, p_prev2, p_prev}, 32'd2);

    // Alignment lost in continuous RUN
    cmd_start = 0;
    step(4);
    cmd_continuous = 1; cmd_start = 1;
    wait_state("align_run", 3'd5, 300, n);
    step(30);
    rx_aligned = 0;
    wait_state("align_fail", 3'd7, 20, n);
    check("align_status", {16'd0, status}, {16'd0, mk(m_pc, 3, 1, 0, 0, 7)});
    rx_aligned = 1;

    // Abort in RESTART
    cmd_start = 0;
    step(4);
    cmd_continuous = 0; cmd_start = 1;
    wait_state("abort_restart", 3'd4, 300, n);
    cmd_abort = 1;
    wait_state("abort_idle", 3'd0, 10, n);
    check("abort_sys_reset", {31'd0, sys_reset}, 32'd1);
    check("abort_lbus", {31'd0, lbus_tx_rx_restart}, 32'd0);
    check("abort_status", {16'd0, status}, {16'd0, mk(m_pc, 0, 0, 0, 0, 0)});

    // Abort coincident with a start edge: start discarded
    cmd_abort = 0; cmd_start = 0;
    step(6);
    cmd_abort = 1; cmd_start = 1;
    step(10);
    check("coinc_idle", {29'd0, status[2:0]}, 32'd0);
    cmd_abort = 0;
    step(10);
    check("coinc_no_start", {29'd0, status[2:0]}, 32'd0);
    check("coinc_sys_reset", {31'd0, sys_reset}, 32'd1);

    // Asynchronous reset mid-RUN clears everything including the pass counter
    cmd_start = 0;
    step(4);
    cmd_continuous = 1; cmd_start = 1;
    wait_state("rst_run", 3'd5, 300, n);
    step(20);
    #2 sys_rstn = 0;
    #1;
    check("arst_sys_reset", {31'd0, sys_reset}, 32'd1);
    check("arst_ctrl", {29'd0, loopback_en, lbus_tx_rx_restart, send_continuous_pkts}, 32'd0);
    check("arst_status", {16'd0, status}, 32'd0);
    cmd_start = 0; cmd_continuous = 0;
    m_pc = 0;
    step(2);
    sys_rstn = 1;
    step(5);
    check("arst_idle", {16'd0, status}, 32'd0);
    do_run(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
